// File: rtl/decode_queue_if.sv
// Fetch/decode handshake bundle for decode_queue: multi-lane push side,
// multi-lane pop side and the occupancy count.
interface decode_queue_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0]    in_valid;
  logic [WIDTH*32-1:0] in_pc;
  logic [WIDTH*32-1:0] in_instr;
  logic [WIDTH*6-1:0]  in_exc;
  logic [WIDTH-1:0]    in_is_jump;
  logic                in_ready;
  logic [WIDTH-1:0]    out_valid;
  logic [WIDTH*32-1:0] out_pc;
  logic [WIDTH*32-1:0] out_instr;
  logic [WIDTH*6-1:0]  out_exc;
  logic [WIDTH-1:0]    out_in_ds;
  logic [WIDTH-1:0]    out_ready;
  logic [CNT_W-1:0]    count;

  modport master (
    output in_valid, in_pc, in_instr, in_exc, in_is_jump, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_exc, out_in_ds, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_exc, in_is_jump, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_exc, out_in_ds, count
  );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane circular instruction queue between fetch and decode; tags each
// entry with a delay-slot flag taken from the previously pushed entry.
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  decode_queue_if.slave  q
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_jump_q, last_jump_d;

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [5:0]  exc_q   [DEPTH];
  logic        ds_q    [DEPTH];

  logic             push_ok;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;
  logic [WIDTH-1:0] ds_lane;
  logic             jump_hi;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic thermo(input logic [WIDTH-1:0] v);
    return (v & (v + 1'b1)) == '0;
  endfunction

  // Room check looks only at registered occupancy, so a same-cycle pop never frees space.
  assign q.in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
  assign q.count    = count_q;

  assign push_ok = q.in_ready && !flush;
  assign push_n  = push_ok ? popcnt(q.in_valid) : '0;
  assign pop_n   = popcnt(q.out_valid & q.out_ready);

  always_comb begin
    ds_lane    = '0;
    ds_lane[0] = last_jump_q;
    for (int i = 1; i < WIDTH; i++) ds_lane[i] = q.in_is_jump[i-1];
  end

  // is_jump of the highest offered lane becomes the next push's lane-0 tag.
  always_comb begin
    jump_hi = last_jump_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (q.in_valid[i]) jump_hi = q.in_is_jump[i];
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_jump_d = last_jump_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      last_jump_d = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      count_d  = count_q + push_n - pop_n;
      if (push_n != '0) last_jump_d = jump_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_jump_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_jump_q <= last_jump_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (push_ok && q.in_valid[i]) begin
        pc_q[wr_ptr_q + PTR_W'(i)]    <= q.in_pc[32*i +: 32];
        instr_q[wr_ptr_q + PTR_W'(i)] <= q.in_instr[32*i +: 32];
        exc_q[wr_ptr_q + PTR_W'(i)]   <= q.in_exc[6*i +: 6];
        ds_q[wr_ptr_q + PTR_W'(i)]    <= ds_lane[i];
      end
    end
  end

  always_comb begin
    q.out_valid = '0;
    q.out_pc    = '0;
    q.out_instr = '0;
    q.out_exc   = '0;
    q.out_in_ds = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        q.out_valid[i]        = 1'b1;
        q.out_pc[32*i +: 32]    = pc_q[rd_ptr_q + PTR_W'(i)];
        q.out_instr[32*i +: 32] = instr_q[rd_ptr_q + PTR_W'(i)];
        q.out_exc[6*i +: 6]     = exc_q[rd_ptr_q + PTR_W'(i)];
        q.out_in_ds[i]          = ds_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

  a_thermo: assert property (@(posedge clk) disable iff (reset)
    thermo(q.in_valid) && thermo(q.out_ready))
    else $error("decode_queue: non-thermometer in_valid/out_ready");

endmodule
